// File: rtl/param_arith_pkg.sv
// param_arith_pkg: shared FSM state type and digit-serial sizing helpers.
package param_arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_w(input int width, input int digit);
    return (width / digit) > 1 ? $clog2(width / digit) : 1;
  endfunction
endpackage

// File: rtl/param_seq_adder_if.sv
// param_seq_adder_if: operand/result handshake bundle.
// Ports: in_valid/in_ready/a/b/cin (operands in), out_valid/out_ready/sum/carry (result out).
interface param_seq_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, carry);
  modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, carry);
endinterface

// File: rtl/param_digit_adder.sv
// param_digit_adder: combinational DIGIT-bit adder with carry in/out.
// Ports: a_d, b_d (digit operands), c_in (carry in), s_d (digit sum), c_out (carry out).
module param_digit_adder #(parameter int DIGIT = 2) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out
);
  assign {c_out, s_d} = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, c_in};
endmodule

// File: rtl/param_seq_adder.sv
// param_seq_adder: digit-serial adder, DIGIT bits per clock, valid/ready in and out.
// Ports: clk, rst (async active-high), bus (slave side of param_seq_adder_if).
module param_seq_adder
  import param_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  param_seq_adder_if.slave   bus
);
  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(WIDTH, DIGIT);
  if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_cfg
    $error("param_seq_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
  logic             rc_q, rc_d, carry_q, carry_d;
  logic [DIGIT-1:0] dig_s;
  logic             dig_c;
  logic             last;
  // Operands shift right each RUN cycle, so the current digit is always the low slice.
  param_digit_adder #(.DIGIT(DIGIT)) u_dig (
    .a_d  (opa_q[DIGIT-1:0]),
    .b_d  (opb_q[DIGIT-1:0]),
    .c_in (rc_q),
    .s_d  (dig_s),
    .c_out(dig_c)
  );
  assign last = cnt_q == CW'(NDIG - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rc_d    = rc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (state_q == IDLE && bus.in_valid) begin
      state_d = RUN;
      opa_d   = bus.a;
      opb_d   = bus.b;
      rc_d    = bus.cin;
      sum_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      opa_d = opa_q >> DIGIT;
      opb_d = opb_q >> DIGIT;
      rc_d  = dig_c;
      sum_d[cnt_q*DIGIT +: DIGIT] = dig_s;
      // Counter parks on the last digit instead of wrapping.
      cnt_d   = last ? cnt_q : cnt_q + 1'b1;
      state_d = last ? DONE : RUN;
      carry_d = last ? dig_c : carry_q;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rc_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rc_q    <= rc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
endmodule
